ccff_chain_loader: RTL and testbench
====================================

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 Parameter LEN_W, default 16: width of the chain-length and bit-counter fields.
REQ-002 prog_clk  in  1  sole clock; chain flops and loader share it.
REQ-003 prog_reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse; begins a load session, honoured only in IDLE.
REQ-005 chain_len  in  LEN_W  total ccff bits in the downstream chain; sampled on accepted start.
REQ-006 wr_data  in  8  configuration byte, MSB shifted first.
REQ-007 wr_valid / wr_ready  in / out  1 each  byte handshake; transfer when both high at a prog_clk edge.
REQ-008 ccff_head  out  1  serial bit driven into the chain head.
REQ-009 shift_en  out  1  chain clock-enable; chain captures ccff_head at an edge where shift_en=1.
REQ-010 ccff_tail  in  1  serial bit returned from the chain tail (old contents).
REQ-011 rd_data  out  8  packed readback byte, MSB-first.
REQ-012 rd_valid / rd_ready  out / in  1 each  readback handshake; rd_data stable while rd_valid=1 and rd_ready=0.
REQ-013 busy  out  1  high outside IDLE.
REQ-014 done  out  1  one-cycle pulse on session completion.

Function
REQ-015 States: IDLE, FETCH, SHIFT, FLUSH, FINISH.
REQ-016 IDLE: start=1 with chain_len>0 latches chain_len into remain and enters FETCH; start with chain_len=0 enters FINISH directly.
REQ-017 FETCH: wr_ready=1; on wr_valid the byte loads the 8-bit shift register, bit index resets to 7, and the FSM enters SHIFT next cycle.
REQ-018 SHIFT: ccff_head = current shift-register bit; shift_en=1 only when the readback packer can accept a bit (not holding a full, unaccepted byte).
REQ-019 In each shift_en=1 cycle: ccff_tail is sampled into the packer, remain decrements, bit index decrements.
REQ-020 After the bit with index 0 is shifted with remain>0, return to FETCH; the chain holds (shift_en=0) while wr_valid is low (underrun stalls, never corrupts).
REQ-021 When remain reaches 0, remaining bits of the current byte are discarded and the FSM enters FLUSH.
REQ-022 Packer: 8 collected bits raise rd_valid with the byte; rd_valid drops the cycle after rd_ready acceptance.
REQ-023 FLUSH: a partial packer byte is emitted left-aligned, zero-padded; FSM waits until rd_valid is accepted (or no partial byte exists), then enters FINISH.
REQ-024 FINISH: done=1 for exactly one cycle, then IDLE.
REQ-025 start while busy is ignored; wr_ready=0 outside FETCH; shift_en=0 outside SHIFT.
REQ-026 Total shift_en=1 cycles per session SHALL equal chain_len exactly; total rd bytes = ceil(chain_len/8).
REQ-027 A byte accepted and a readback byte accepted in the same cycle are both honoured.

Reset
REQ-028 On prog_reset: state IDLE; ccff_head=0, shift_en=0, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0; counters and shift registers cleared.
REQ-029 Reset mid-session aborts immediately; the chain keeps partially shifted contents; no done pulse.

Structure
REQ-030 Shared package holds the FSM state enum and LEN_W default.
REQ-031 One sub-module, ccff_readback_packer (serial-in, byte-out with valid/ready and flush), is instantiated once.

Verification
REQ-032 chain_len=24, bytes A5,3C,F0, rd_ready=1, model chain all-zero -> 24 shift_en cycles, head sequence 1010_0101_0011_1100_1111_0000, rd bytes 00,00,00, one done.
REQ-033 chain_len=10, bytes C3,80, chain preloaded 10'b11_0000_0001 -> exactly 10 shifts, readback bytes C0,40, chain ends holding 1100001110.
REQ-034 chain_len=16, wr_valid low 5 cycles between bytes -> shift_en low during gap, chain content identical to no-gap run.
REQ-035 chain_len=16, rd_ready low 20 cycles after first byte -> shift_en stalls after 8 bits, resumes on acceptance, no bit lost.
REQ-036 start with chain_len=0 -> no shift_en, no wr_ready, done pulse 1 cycle later.
REQ-037 prog_reset asserted after 5 shifts of a 24-bit load -> all outputs at reset values same cycle; new start then loads cleanly.

Source files
------------

// File: rtl/ccff_chain_loader_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states and the
// default width of the chain-length / bit-counter fields.
package ccff_chain_loader_pkg;

  localparam int LEN_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/ccff_readback_packer.sv
// Collects old chain bits (first bit lands in the MSB) into bytes and offers
// them on a valid/ready port. A flush emits a partial byte left-aligned with
// zero padding. New bits are refused while a completed byte is still waiting.
module ccff_readback_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_bit_valid,
  input  logic       i_bit,
  input  logic       i_flush,
  output logic       o_can_accept,
  output logic       o_empty,
  output logic [7:0] o_rd_data,
  output logic       o_rd_valid,
  input  logic       i_rd_ready
);

  logic [6:0] r_acc;
  logic [2:0] r_cnt;
  logic [7:0] r_rd_data;
  logic       r_rd_valid;
  logic [7:0] w_pad_byte;

  // Partial byte: r_cnt bits sit in r_acc[r_cnt-1:0]; move them up to bit 7.
  assign w_pad_byte   = {r_acc, 1'b0} << (3'd7 - r_cnt);

  // Only registered state feeds the accept flag, so the loader's shift enable
  // has no combinational path from rd_ready.
  assign o_can_accept = ~r_rd_valid;
  assign o_empty      = ~r_rd_valid & (r_cnt == 3'd0);
  assign o_rd_data    = r_rd_data;
  assign o_rd_valid   = r_rd_valid;

  // Accumulate bits, publish full or flushed bytes, retire accepted bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (r_rd_valid) begin
      if (i_rd_ready) begin
        r_rd_valid <= 1'b0;
      end
    end else if (i_bit_valid) begin
      if (r_cnt == 3'd7) begin
        r_rd_data  <= {r_acc, i_bit};
        r_rd_valid <= 1'b1;
        r_acc      <= '0;
        r_cnt      <= '0;
      end else begin
        r_acc <= {r_acc[5:0], i_bit};
        r_cnt <= r_cnt + 3'd1;
      end
    end else if (i_flush && (r_cnt != 3'd0)) begin
      r_rd_data  <= w_pad_byte;
      r_rd_valid <= 1'b1;
      r_acc      <= '0;
      r_cnt      <= '0;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serial loader for a ccff configuration chain. Bytes arrive MSB-first on the
// write port and are shifted into the chain head; the old chain contents come
// back on the tail and are repacked into bytes on the readback port.
//
// Handshakes (write and readback): a transfer happens at a prog_clk edge where
// valid and ready are both high; the source keeps data stable while valid is
// high and ready is low, and neither side waits for the other to drop.
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic             prog_clk,
  input  logic             prog_reset,
  input  logic             start,
  input  logic [LEN_W-1:0] chain_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic             ccff_head,
  output logic             shift_en,
  input  logic             ccff_tail,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             busy,
  output logic             done,
  output state_t           o_dbg_state
);

  state_t           r_state;
  logic [LEN_W-1:0] r_remain;
  logic [7:0]       r_sreg;
  logic [2:0]       r_idx;

  logic             w_shift_en;
  logic             w_pack_can_accept;
  logic             w_pack_empty;
  logic             w_flush;

  // A bit moves only when the packer has room for the tail bit it returns,
  // so the chain never advances without its old bit being captured.
  assign w_shift_en  = (r_state == ST_SHIFT) & w_pack_can_accept;
  assign w_flush     = (r_state == ST_FLUSH);

  assign shift_en    = w_shift_en;
  assign ccff_head   = (r_state == ST_SHIFT) & r_sreg[7];
  assign wr_ready    = (r_state == ST_FETCH);
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_FINISH);
  assign o_dbg_state = r_state;

  // Session sequencing: fetch a byte, shift it out, repeat until the chain
  // length is used up, then drain the packer and pulse done.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      r_state  <= ST_IDLE;
      r_remain <= '0;
      r_sreg   <= '0;
      r_idx    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (chain_len != '0) begin
              r_remain <= chain_len;
              r_state  <= ST_FETCH;
            end else begin
              r_state  <= ST_FINISH;
            end
          end
        end
        ST_FETCH: begin
          if (wr_valid) begin
            r_sreg  <= wr_data;
            r_idx   <= 3'd7;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_shift_en) begin
            r_sreg   <= {r_sreg[6:0], 1'b0};
            r_remain <= r_remain - LEN_W'(1);
            r_idx    <= r_idx - 3'd1;
            // Last chain bit wins over the byte boundary: leftover bits of
            // the current byte are simply dropped.
            if (r_remain == LEN_W'(1)) begin
              r_state <= ST_FLUSH;
            end else if (r_idx == 3'd0) begin
              r_state <= ST_FETCH;
            end
          end
        end
        ST_FLUSH: begin
          if (w_pack_empty) begin
            r_state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  ccff_readback_packer u_packer (
    .clk          (prog_clk),
    .rst          (prog_reset),
    .i_bit_valid  (w_shift_en),
    .i_bit        (ccff_tail),
    .i_flush      (w_flush),
    .o_can_accept (w_pack_can_accept),
    .o_empty      (w_pack_empty),
    .o_rd_data    (rd_data),
    .o_rd_valid   (rd_valid),
    .i_rd_ready   (rd_ready)
  );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a behavioural chain model on the head/tail
// pins, a scoreboard of expected head bits and readback bytes, directed
// scenarios and randomized sessions.
module tb_ccff_chain_loader;
  import ccff_chain_loader_pkg::*;

  localparam int LW = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          prog_clk = 1'b0;
  logic          prog_reset;
  logic          start;
  logic [LW-1:0] chain_len;
  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          ccff_head;
  logic          shift_en;
  logic          ccff_tail;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          busy;
  logic          done;
  state_t        dbg_state;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.LEN_W(LW)) dut (
    .prog_clk    (prog_clk),
    .prog_reset  (prog_reset),
    .start       (start),
    .chain_len   (chain_len),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .ccff_head   (ccff_head),
    .shift_en    (shift_en),
    .ccff_tail   (ccff_tail),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic       exp_head_q[$];
  logic [7:0] exp_rd_q[$];
  logic       chain_q[$];   // front = tail end of the chain
  logic       pre_q[$];
  logic [7:0] tx_q[$];
  int         sess_shift = 0;
  int         done_cnt = 0;
  int         wr_rdy_cnt = 0;
  int         rd_mode = 0;
  int         stall_left = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic head_bit(input int idx);
    logic [7:0] b;
    b = tx_q[idx / 8];
    return b[7 - (idx % 8)];
  endfunction

  // Expected head bits: the first len bits of the byte stream, MSB-first.
  // Expected readback: the first len old chain bits (tail first), packed
  // MSB-first, last byte zero-padded on the right.
  task automatic build_expect(input int len);
    int nb;
    logic [7:0] b;
    exp_head_q.delete();
    exp_rd_q.delete();
    for (int i = 0; i < len; i++) exp_head_q.push_back(head_bit(i));
    nb = (len + 7) / 8;
    for (int i = 0; i < nb; i++) begin
      b = '0;
      for (int j = 0; j < 8; j++) begin
        b = {b[6:0], ((i * 8 + j) < len) ? chain_q[i * 8 + j] : 1'b0};
      end
      exp_rd_q.push_back(b);
    end
  endtask

  task automatic load_chain_vec(input int len, input logic [63:0] v);
    chain_q.delete();
    for (int i = 0; i < len; i++) chain_q.push_back(v[len - 1 - i]);
    ccff_tail = chain_q[0];
  endtask

  task automatic load_chain_rand(input int len);
    chain_q.delete();
    for (int i = 0; i < len; i++) chain_q.push_back(1'($urandom_range(0, 1)));
    ccff_tail = chain_q[0];
  endtask

  task automatic make_tx(input int len);
    tx_q.delete();
    for (int i = 0; i < (len + 7) / 8; i++) tx_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Chain of flops: captures ccff_head at an edge where shift_en is high.
  logic m_en, m_hd;
  always begin
    @(negedge prog_clk);
    m_en = shift_en;
    m_hd = ccff_head;
    @(posedge prog_clk);
    if (m_en && !prog_reset && chain_q.size() > 0) begin
      void'(chain_q.pop_front());
      chain_q.push_back(m_hd);
    end
    #1;
    if (chain_q.size() > 0) ccff_tail = chain_q[0];
  end

  // Readback sink: always ready, random, or a scripted stall.
  always @(posedge prog_clk) begin
    #1;
    case (rd_mode)
      0: rd_ready = 1'b1;
      1: rd_ready = 1'($urandom_range(0, 1));
      default: begin
        if (rd_valid && stall_left > 0) begin
          rd_ready = 1'b0;
          stall_left--;
        end else begin
          rd_ready = 1'b1;
        end
      end
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge prog_clk) begin
    if (prog_reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) check("rd_stable", {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, prev_data});
      if (shift_en) begin
        sess_shift++;
        check("excl_wr_shift", wr_ready, 0);
        if (exp_head_q.size() == 0) fail_now("head_extra");
        else check("head_bit", ccff_head, exp_head_q.pop_front());
      end
      if (rd_valid && !rd_ready) check("stall_shift", shift_en, 0);
      if (rd_valid && rd_ready) begin
        if (exp_rd_q.size() == 0) fail_now("rd_extra");
        else check("rd_byte", rd_data, exp_rd_q.pop_front());
      end
      if (done) done_cnt++;
      if (wr_ready) wr_rdy_cnt++;
      prev_hold = rd_valid && !rd_ready;
      prev_data = rd_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int len);
    @(posedge prog_clk); #1;
    start = 1'b1;
    chain_len = LW'(len);
    @(posedge prog_clk); #1;
    start = 1'b0;
    chain_len = LW'($urandom_range(0, 65535));
  endtask

  task automatic wait_wr_ready(output bit ok);
    int t;
    t = 0;
    @(negedge prog_clk);
    while (!wr_ready && t < 500) begin
      @(negedge prog_clk);
      t++;
    end
    ok = wr_ready;
  endtask

  task automatic run_session(input int len, input int gap_lo, input int gap_hi, input bit poke);
    int nb, db, g, t, mism;
    bit ok;
    build_expect(len);
    sess_shift = 0;
    db = done_cnt;
    nb = (len + 7) / 8;
    pulse_start(len);
    for (int i = 0; i < nb; i++) begin
      if (i > 0) begin
        g = $urandom_range(gap_lo, gap_hi);
        if (g > 0) begin
          wait_wr_ready(ok);
          if (!ok) begin
            fail_now("gap_wr_timeout");
            break;
          end
          repeat (g) begin
            check("gap_hold", {shift_en, wr_ready}, 2'b01);
            @(negedge prog_clk);
          end
          @(posedge prog_clk); #1;
        end
      end
      wr_valid = 1'b1;
      wr_data = tx_q[i];
      wait_wr_ready(ok);
      if (!ok) begin
        fail_now("wr_timeout");
        wr_valid = 1'b0;
        break;
      end
      @(posedge prog_clk); #1;
      wr_valid = 1'b0;
      wr_data = 8'($urandom_range(0, 255));
      if (poke && i == 0) begin
        start = 1'b1;
        chain_len = LW'(len + 3);
        @(posedge prog_clk); #1;
        start = 1'b0;
      end
    end
    t = 0;
    while (done_cnt == db && t < 3000) begin
      @(negedge prog_clk);
      t++;
    end
    if (done_cnt == db) fail_now("done_timeout");
    repeat (3) @(negedge prog_clk);
    check("shift_count", sess_shift, len);
    check("done_count", done_cnt - db, 1);
    check("head_left", exp_head_q.size(), 0);
    check("rd_left", exp_rd_q.size(), 0);
    check("idle_after", {busy, wr_ready, shift_en, rd_valid}, 0);
    mism = 0;
    for (int i = 0; i < len; i++) if (chain_q[i] !== head_bit(i)) mism++;
    check("chain_final", mism, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0, db, t, mism, lens[4];
    logic [9:0] v10;
    bit ok;
    prog_reset = 1'b1;
    start = 1'b0;
    chain_len = '0;
    wr_data = '0;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    chain_q.push_back(1'b0);
    ccff_tail = 1'b0;
    #1;
    check("reset_outs", {ccff_head, shift_en, wr_ready, rd_valid, busy, done, rd_data}, 0);
    check("reset_state", dbg_state, ST_IDLE);
    repeat (3) @(posedge prog_clk);
    #2 prog_reset = 1'b0;

    // 24 bits into an all-zero chain
    tx_q = '{8'hA5, 8'h3C, 8'hF0};
    load_chain_vec(24, 64'd0);
    run_session(24, 0, 0, 1'b0);

    // 10 bits with a known preload: readback C0,40
    tx_q = '{8'hC3, 8'h80};
    load_chain_vec(10, 64'b11_0000_0001);
    run_session(10, 0, 0, 1'b0);
    v10 = '0;
    for (int i = 0; i < 10; i++) v10 = {v10[8:0], chain_q[i]};
    check("chain_10_final", v10, 10'b1100001110);

    // write underrun: five idle cycles while the loader waits for a byte
    make_tx(16);
    load_chain_rand(16);
    run_session(16, 5, 5, 1'b0);

    // readback back-pressure: 20 cycles of rd_ready low on the first byte
    rd_mode = 2;
    stall_left = 20;
    make_tx(16);
    load_chain_rand(16);
    run_session(16, 0, 0, 1'b0);
    check("stall_consumed", stall_left, 0);
    rd_mode = 0;

    // zero-length session
    sess_shift = 0;
    w0 = wr_rdy_cnt;
    pulse_start(0);
    @(negedge prog_clk);
    check("zl_done", {done, busy}, 2'b11);
    @(negedge prog_clk);
    check("zl_done_clear", {done, busy}, 2'b00);
    check("zl_no_wr", wr_rdy_cnt - w0, 0);
    check("zl_no_shift", sess_shift, 0);

    // reset after five shifts of a 24-bit load
    make_tx(24);
    load_chain_rand(24);
    pre_q = chain_q;
    build_expect(24);
    sess_shift = 0;
    db = done_cnt;
    pulse_start(24);
    wr_valid = 1'b1;
    wr_data = tx_q[0];
    wait_wr_ready(ok);
    if (!ok) fail_now("abort_wr_timeout");
    @(posedge prog_clk); #1;
    wr_valid = 1'b0;
    t = 0;
    while (sess_shift < 5 && t < 100) begin
      @(posedge prog_clk); #2;
      t++;
    end
    check("abort_shifts", sess_shift, 5);
    prog_reset = 1'b1;
    #1;
    check("abort_outs", {ccff_head, shift_en, wr_ready, rd_valid, busy, done, rd_data}, 0);
    check("abort_state", dbg_state, ST_IDLE);
    mism = 0;
    for (int i = 0; i < 19; i++) if (chain_q[i] !== pre_q[i + 5]) mism++;
    for (int i = 0; i < 5; i++) if (chain_q[19 + i] !== head_bit(i)) mism++;
    check("abort_chain", mism, 0);
    exp_head_q.delete();
    exp_rd_q.delete();
    repeat (3) @(posedge prog_clk);
    #2 prog_reset = 1'b0;
    repeat (2) @(negedge prog_clk);
    check("abort_no_done", done_cnt - db, 0);
    make_tx(24);
    load_chain_rand(24);
    run_session(24, 0, 2, 1'b0);

    // boundary lengths around a byte
    lens = '{1, 7, 8, 9};
    foreach (lens[k]) begin
      make_tx(lens[k]);
      load_chain_rand(lens[k]);
      run_session(lens[k], 0, 1, 1'b0);
    end

    // randomized sessions with random back-pressure and start pokes
    rd_mode = 1;
    repeat (10) begin
      t = $urandom_range(1, 40);
      make_tx(t);
      load_chain_rand(t);
      run_session(t, 0, 4, 1'b1);
    end
    rd_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
